// File: rtl/uno_pkg.sv
// Shared card types, constants and the play-legality rule for the player hand.
package uno_pkg;

  typedef struct packed {
    logic [1:0] color;
    logic [3:0] value;
  } card_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BLUE   = 2'd3;

  localparam logic [3:0] VAL_SKIP  = 4'd10;
  localparam logic [3:0] VAL_REV   = 4'd11;
  localparam logic [3:0] VAL_DRAW2 = 4'd12;
  localparam logic [3:0] VAL_WILD  = 4'd13;
  localparam logic [3:0] VAL_WILD4 = 4'd14;

  localparam logic [2:0] DRAW_ONE  = 3'b001;
  localparam logic [2:0] DRAW_TWO  = 3'b010;
  localparam logic [2:0] DRAW_FOUR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_DECK,
    S_DRAW,
    S_COMPACT
  } state_t;

  // Wilds always play; otherwise match the active colour or the top card's value.
  function automatic logic is_legal(card_t card, card_t top, logic [1:0] cur_color);
    return (card.value == VAL_WILD) || (card.value == VAL_WILD4) ||
           (card.color == cur_color) || (card.value == top.value);
  endfunction

endpackage

// File: rtl/card_legal_check.sv
// Combinational legality test of one held card against the discard pile.
module card_legal_check
  import uno_pkg::*;
(
  input  card_t      card_i,
  input  card_t      top_i,
  input  logic [1:0] cur_color_i,
  output logic       legal_o
);

  assign legal_o = is_legal(card_i, top_i, cur_color_i);

endmodule

// File: rtl/player_hand.sv
// One player's hand: collects cards from the deck, validates and removes played cards,
// and closes the gap left by a play one slot per cycle.
module player_hand
  import uno_pkg::*;
#(
  parameter  int unsigned MAX_CARDS = 32,
  localparam int unsigned IW        = $clog2(MAX_CARDS),
  localparam int unsigned CW        = IW + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic [2:0]           i_draw_req,
  output logic [2:0]           o_draw,
  input  logic                 i_deck_done,
  input  logic                 i_deck_drawn,
  input  logic [5:0]           i_deck_card,
  input  logic                 i_play,
  input  logic [IW-1:0]        i_play_idx,
  input  logic [5:0]           i_top_card,
  input  logic [1:0]           i_cur_color,
  input  logic [IW-1:0]        i_rd_idx,
  output logic [5:0]           o_rd_card,
  output logic [MAX_CARDS-1:0] o_legal_mask,
  output logic [CW-1:0]        o_count,
  output logic                 o_busy,
  output logic                 o_draw_done,
  output logic                 o_play_ok,
  output logic                 o_play_err,
  output logic [5:0]           o_played_card,
  output logic                 o_overflow
);

  state_t          state_q, state_d;
  card_t           slot_q [MAX_CARDS];
  card_t           slot_d [MAX_CARDS];
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [2:0]      remaining_q, remaining_d;
  logic [2:0]      code_q, code_d;
  logic [2:0]      draw_q, draw_d;
  logic            draw_done_q, draw_done_d;
  logic            play_ok_q, play_ok_d;
  logic            play_err_q, play_err_d;
  card_t           played_q, played_d;
  logic            overflow_q, overflow_d;

  card_t           top_card;
  logic [MAX_CARDS-1:0] legal_mask_c;
  logic            req_valid;
  logic            play_legal;
  logic [IW-1:0]   ptr_next;

  assign top_card  = card_t'(i_top_card);
  assign req_valid = (i_draw_req == DRAW_ONE) || (i_draw_req == DRAW_TWO) ||
                     (i_draw_req == DRAW_FOUR);
  assign ptr_next  = ptr_q + IW'(1);

  // Per-slot legality, masked by occupancy; the play path reads the same mask.
  for (genvar g = 0; g < MAX_CARDS; g++) begin : g_slot
    logic legal;
    card_legal_check u_chk (
      .card_i      (slot_q[g]),
      .top_i       (top_card),
      .cur_color_i (i_cur_color),
      .legal_o     (legal)
    );
    assign legal_mask_c[g] = legal && (CW'(g) < count_q);
  end

  assign play_legal = legal_mask_c[i_play_idx];

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    code_d      = code_q;
    draw_d      = draw_q;
    draw_done_d = 1'b0;
    play_ok_d   = 1'b0;
    play_err_d  = 1'b0;
    played_d    = played_q;
    overflow_d  = overflow_q;

    if (i_clear) begin
      state_d    = S_IDLE;
      count_d    = '0;
      draw_d     = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            code_d      = i_draw_req;
            remaining_d = (i_draw_req == DRAW_ONE) ? 3'd1 :
                          (i_draw_req == DRAW_TWO) ? 3'd2 : 3'd4;
            state_d     = S_WAIT_DECK;
            play_err_d  = i_play;
          end else if (i_play) begin
            if (play_legal) begin
              played_d  = slot_q[i_play_idx];
              play_ok_d = 1'b1;
              count_d   = count_q - CW'(1);
              ptr_d     = i_play_idx;
              if (CW'(i_play_idx) == count_q - CW'(1)) begin
                slot_d[i_play_idx] = '0;
              end else begin
                state_d = S_COMPACT;
              end
            end else begin
              play_err_d = 1'b1;
            end
          end
        end
        S_WAIT_DECK: begin
          if (i_deck_done) begin
            state_d = S_DRAW;
            draw_d  = code_q;
          end
        end
        S_DRAW: begin
          if (i_deck_drawn) begin
            if (count_q < CW'(MAX_CARDS)) begin
              slot_d[IW'(count_q)] = card_t'(i_deck_card);
              count_d              = count_q + CW'(1);
            end else begin
              overflow_d = 1'b1;
            end
            remaining_d = remaining_q - 3'd1;
            if (remaining_q == 3'd1) begin
              state_d     = S_IDLE;
              draw_d      = '0;
              draw_done_d = 1'b1;
            end
          end
        end
        S_COMPACT: begin
          // count_q already holds the post-play count, so the last moved slot is count_q.
          slot_d[ptr_q] = slot_q[ptr_next];
          ptr_d         = ptr_next;
          if (CW'(ptr_next) == count_q) begin
            slot_d[ptr_next] = '0;
            state_d          = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < int'(MAX_CARDS); i++) slot_q[i] <= '0;
      count_q     <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      code_q      <= '0;
      draw_q      <= '0;
      draw_done_q <= 1'b0;
      play_ok_q   <= 1'b0;
      play_err_q  <= 1'b0;
      played_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      code_q      <= code_d;
      draw_q      <= draw_d;
      draw_done_q <= draw_done_d;
      play_ok_q   <= play_ok_d;
      play_err_q  <= play_err_d;
      played_q    <= played_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_draw        = draw_q;
  assign o_draw_done   = draw_done_q;
  assign o_play_ok     = play_ok_q;
  assign o_play_err    = play_err_q;
  assign o_played_card = played_q;
  assign o_overflow    = overflow_q;
  assign o_count       = count_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_legal_mask  = legal_mask_c;
  assign o_rd_card     = (CW'(i_rd_idx) < count_q) ? slot_q[i_rd_idx] : 6'd0;

endmodule

// File: tb/tb_player_hand.sv
// Bench for player_hand: directed scenarios plus random traffic, all checked every cycle
// against a queue-based model of the hand.
module tb_player_hand;

  localparam int unsigned MAXC = 4;
  localparam int unsigned IW   = $clog2(MAXC);
  localparam int unsigned CW   = IW + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic [2:0]      draw_req = '0;
  logic [2:0]      o_draw;
  logic            deck_done = 1'b0;
  logic            deck_drawn = 1'b0;
  logic [5:0]      deck_card = '0;
  logic            play = 1'b0;
  logic [IW-1:0]   play_idx = '0;
  logic [5:0]      top_card = '0;
  logic [1:0]      cur_color = '0;
  logic [IW-1:0]   rd_idx = '0;
  logic [5:0]      o_rd_card;
  logic [MAXC-1:0] o_legal_mask;
  logic [CW-1:0]   o_count;
  logic            o_busy, o_draw_done, o_play_ok, o_play_err, o_overflow;
  logic [5:0]      o_played_card;

  int vectors = 0;
  int miscompares = 0;

  player_hand #(.MAX_CARDS(MAXC)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_clear       (clear),
    .i_draw_req    (draw_req),
    .o_draw        (o_draw),
    .i_deck_done   (deck_done),
    .i_deck_drawn  (deck_drawn),
    .i_deck_card   (deck_card),
    .i_play        (play),
    .i_play_idx    (play_idx),
    .i_top_card    (top_card),
    .i_cur_color   (cur_color),
    .i_rd_idx      (rd_idx),
    .o_rd_card     (o_rd_card),
    .o_legal_mask  (o_legal_mask),
    .o_count       (o_count),
    .o_busy        (o_busy),
    .o_draw_done   (o_draw_done),
    .o_play_ok     (o_play_ok),
    .o_play_err    (o_play_err),
    .o_played_card (o_played_card),
    .o_overflow    (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [5:0] hand[$];
  bit         m_wait = 0, m_drawing = 0, m_ovf = 0;
  bit         m_done = 0, m_ok = 0, m_err = 0;
  int         m_compact = 0, m_remaining = 0;
  logic [2:0] m_code = '0, m_draw = '0;
  logic [5:0] m_played = '0;

  function automatic bit legal(input logic [5:0] c, input logic [5:0] top, input logic [1:0] cc);
    return (c[3:0] == 4'd13) || (c[3:0] == 4'd14) || (c[5:4] == cc) || (c[3:0] == top[3:0]);
  endfunction

  function automatic bit one_hot_req(input logic [2:0] r);
    return (r == 3'b001) || (r == 3'b010) || (r == 3'b100);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hand.delete();
      m_wait = 0; m_drawing = 0; m_ovf = 0; m_compact = 0;
      m_done = 0; m_ok = 0; m_err = 0; m_draw = '0; m_played = '0;
    end else begin
      m_done = 0; m_ok = 0; m_err = 0;
      if (clear) begin
        hand.delete();
        m_wait = 0; m_drawing = 0; m_compact = 0; m_draw = '0; m_ovf = 0;
      end else if (m_wait) begin
        if (deck_done) begin
          m_wait = 0; m_drawing = 1; m_draw = m_code;
        end
      end else if (m_drawing) begin
        if (deck_drawn) begin
          if (hand.size() < MAXC) hand.push_back(deck_card);
          else m_ovf = 1;
          m_remaining--;
          if (m_remaining == 0) begin
            m_drawing = 0; m_draw = '0; m_done = 1;
          end
        end
      end else if (m_compact > 0) begin
        m_compact--;
      end else if (one_hot_req(draw_req)) begin
        m_code = draw_req;
        m_remaining = (draw_req == 3'b001) ? 1 : (draw_req == 3'b010) ? 2 : 4;
        m_wait = 1;
        m_err = play;
      end else if (play) begin
        if (int'(play_idx) >= hand.size() || !legal(hand[play_idx], top_card, cur_color)) begin
          m_err = 1;
        end else begin
          m_played = hand[play_idx];
          m_ok = 1;
          m_compact = hand.size() - 1 - int'(play_idx);
          hand.delete(int'(play_idx));
        end
      end
    end
  end

  // Every-cycle comparison; slot contents only when the hand is settled.
  always @(negedge clk) begin
    if (rst_n) begin
      bit busy;
      logic [MAXC-1:0] mask;
      busy = m_wait || m_drawing || (m_compact > 0);
      chk("count", 32'(o_count), 32'(hand.size()));
      chk("busy", 32'(o_busy), 32'(busy));
      chk("draw", 32'(o_draw), 32'(m_draw));
      chk("draw_done", 32'(o_draw_done), 32'(m_done));
      chk("play_ok", 32'(o_play_ok), 32'(m_ok));
      chk("play_err", 32'(o_play_err), 32'(m_err));
      chk("played_card", 32'(o_played_card), 32'(m_played));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      if (!busy) begin
        mask = '0;
        for (int i = 0; i < hand.size(); i++) mask[i] = legal(hand[i], top_card, cur_color);
        chk("legal_mask", 32'(o_legal_mask), 32'(mask));
        chk("rd_card", 32'(o_rd_card),
            (int'(rd_idx) < hand.size()) ? 32'(hand[rd_idx]) : 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [2:0] bad_codes [4];
    bad_codes = '{3'b011, 3'b101, 3'b110, 3'b111};

    // Reset values
    repeat (2) tick();
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_draw", 32'(o_draw), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("rst_played", 32'(o_played_card), 32'd0);
    rst_n = 1'b1;
    tick();

    // Draw two while the deck is not ready for five cycles
    draw_req = 3'b010; tick(); draw_req = '0;
    repeat (5) begin tick(); chk("draw_held_off", 32'(o_draw), 32'd0); end
    deck_done = 1'b1; tick();
    chk("draw_two_code", 32'(o_draw), 32'h2);
    deck_drawn = 1'b1; deck_card = 6'h01; tick();
    deck_card = 6'h12; tick();
    deck_drawn = 1'b0;
    chk("draw_two_count", 32'(o_count), 32'd2);
    chk("draw_two_done", 32'(o_draw_done), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_count", 32'(o_count), 32'd0);

    // Draw four: 05 1A 2D 3E
    draw_req = 3'b100; tick(); draw_req = '0;
    tick();
    chk("draw_four_code", 32'(o_draw), 32'h4);
    deck_drawn = 1'b1;
    deck_card = 6'h05; tick();
    deck_card = 6'h1A; tick();
    deck_card = 6'h2D; tick();
    chk("draw_four_mid", 32'(o_draw), 32'h4);
    deck_card = 6'h3E; tick();
    deck_drawn = 1'b0;
    chk("draw_four_done", 32'(o_draw_done), 32'd1);
    chk("draw_four_count", 32'(o_count), 32'd4);
    rd_idx = 2'd2; #1;
    chk("rd_slot2", 32'(o_rd_card), 32'h2D);
    tick();
    chk("draw_done_one_pulse", 32'(o_draw_done), 32'd0);

    // Play checks against top 0x15, colour red
    top_card = 6'h15; cur_color = 2'd0; #1;
    chk("legal_mask_lit", 32'(o_legal_mask), 32'b1101);
    play = 1'b1; play_idx = 2'd1; tick(); play = 1'b0;
    chk("illegal_err", 32'(o_play_err), 32'd1);
    chk("illegal_count", 32'(o_count), 32'd4);
    tick();
    play = 1'b1; play_idx = 2'd0; tick(); play = 1'b0;
    chk("legal_ok", 32'(o_play_ok), 32'd1);
    chk("legal_played", 32'(o_played_card), 32'h05);
    chk("legal_busy", 32'(o_busy), 32'd1);
    repeat (3) tick();
    chk("compact_idle", 32'(o_busy), 32'd0);
    chk("compact_count", 32'(o_count), 32'd3);
    rd_idx = 2'd0; #1; chk("compact_s0", 32'(o_rd_card), 32'h1A);
    rd_idx = 2'd1; #1; chk("compact_s1", 32'(o_rd_card), 32'h2D);
    rd_idx = 2'd2; #1; chk("compact_s2", 32'(o_rd_card), 32'h3E);
    rd_idx = 2'd3; #1; chk("compact_s3_empty", 32'(o_rd_card), 32'h00);

    // Overflow: three held, draw two into a four-slot hand
    draw_req = 3'b010; tick(); draw_req = '0;
    tick();
    deck_drawn = 1'b1; deck_card = 6'h21; tick();
    deck_card = 6'h32; tick();
    deck_drawn = 1'b0;
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    chk("ovf_count", 32'(o_count), 32'd4);
    chk("ovf_done", 32'(o_draw_done), 32'd1);
    #1; chk("ovf_s3", 32'(o_rd_card), 32'h21);

    // Clear in the middle of a four-card draw
    clear = 1'b1; tick(); clear = 1'b0;
    draw_req = 3'b100; tick(); draw_req = '0;
    tick();
    deck_drawn = 1'b1; deck_card = 6'h07; tick();
    deck_drawn = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    chk("midclr_draw", 32'(o_draw), 32'd0);
    chk("midclr_count", 32'(o_count), 32'd0);
    chk("midclr_ovf", 32'(o_overflow), 32'd0);
    deck_drawn = 1'b1; deck_card = 6'h09; tick();
    deck_drawn = 1'b0; tick();
    chk("late_card_ignored", 32'(o_count), 32'd0);
    chk("no_done_after_clear", 32'(o_draw_done), 32'd0);

    // Random traffic with a mid-run asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      int rr;
      clear      = ($urandom_range(0, 99) < 2);
      play       = ($urandom_range(0, 3) == 0);
      rr         = $urandom_range(0, 9);
      draw_req   = (rr <= 5) ? 3'b000 : (rr == 6) ? 3'b001 : (rr == 7) ? 3'b010 :
                   (rr == 8) ? 3'b100 : bad_codes[$urandom_range(0, 3)];
      if (play && rr == 9) draw_req = 3'b000;
      deck_done  = ($urandom_range(0, 2) != 0);
      deck_drawn = $urandom_range(0, 1) != 0;
      deck_card  = 6'($urandom);
      play_idx   = IW'($urandom);
      top_card   = 6'($urandom);
      cur_color  = 2'($urandom);
      rd_idx     = IW'($urandom);
      if (n == 1500) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        chk("async_rst_count", 32'(o_count), 32'd0);
      end
      tick();
    end

    clear = 1'b0; play = 1'b0; draw_req = '0; deck_drawn = 1'b0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
